// File: rtl/jalr_station.sv
// JALR reservation station: DEPTH entries, operand snooping from the ROB,
// oldest-first issue to the CDB, target = (rs1 + imm) & ~1, link = pc + 4.
module jalr_station #(
  parameter int DEPTH              = 4,
  parameter int ROB_DEPTH          = 8,
  parameter int TAG_W              = $clog2(ROB_DEPTH),
  parameter int HOLD_ON_MISPREDICT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_vj,
  input  logic [TAG_W-1:0]        in_qj,
  input  logic [31:0]             in_a,
  input  logic [TAG_W-1:0]        in_dest,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_pc_next,
  input  logic [ROB_DEPTH-1:0]    rob_ready,
  input  logic [ROB_DEPTH*32-1:0] rob_vals,
  output logic                    res_valid,
  output logic [31:0]             res_val,
  output logic [TAG_W-1:0]        res_tag,
  output logic                    res_correct,
  output logic [31:0]             res_pc_next
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Per-entry state. older[i][j] = 1 means entry i was allocated before entry j;
  // a new entry clears its own row and sets its column, so the relation stays
  // valid no matter in which order entries are freed.
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       reported;
  logic [TAG_W-1:0]       qj      [DEPTH];
  logic [31:0]            vj      [DEPTH];
  logic [31:0]            imm     [DEPTH];
  logic [TAG_W-1:0]       dest    [DEPTH];
  logic [31:0]            pc      [DEPTH];
  logic [31:0]            pc_next [DEPTH];
  logic [DEPTH-1:0]       older   [DEPTH];

  logic [DEPTH-1:0]       eligible;
  logic                   alloc_found;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   issue_found;
  logic [IDX_W-1:0]       issue_idx;
  logic [31:0]            issue_tgt;
  logic                   issue_correct;

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  assign in_ready = alloc_found;

  // Pick the oldest entry whose operand is ready and that has not reported yet.
  always_comb begin
    logic blocked;
    blocked     = 1'b0;
    issue_found = 1'b0;
    issue_idx   = '0;
    eligible    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = busy[i] && (qj[i] == '0) && !reported[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && older[j][i]) blocked = 1'b1;
      end
      if (eligible[i] && !blocked) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  // Target computation for the selected entry.
  always_comb begin
    issue_tgt     = (vj[issue_idx] + imm[issue_idx]) & 32'hFFFF_FFFE;
    issue_correct = (pc_next[issue_idx] == issue_tgt);
  end

  // Entry bookkeeping: snoop, issue/free, dispatch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy     <= '0;
      reported <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && (qj[i] != '0) && rob_ready[qj[i]]) begin
          vj[i] <= rob_vals[32*int'(qj[i]) +: 32];
          qj[i] <= '0;
        end
      end
      if (issue_found) begin
        if (issue_correct || (HOLD_ON_MISPREDICT == 0)) begin
          busy[issue_idx] <= 1'b0;
        end else begin
          reported[issue_idx] <= 1'b1;
        end
      end
      if (in_valid && alloc_found) begin
        busy[alloc_idx]     <= 1'b1;
        reported[alloc_idx] <= 1'b0;
        qj[alloc_idx]       <= in_qj;
        vj[alloc_idx]       <= in_vj;
        imm[alloc_idx]      <= in_a;
        dest[alloc_idx]     <= in_dest;
        pc[alloc_idx]       <= in_pc;
        pc_next[alloc_idx]  <= in_pc_next;
        older[alloc_idx]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != int'(alloc_idx)) older[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

  // Registered CDB result; payload holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      res_valid   <= 1'b0;
      res_val     <= '0;
      res_tag     <= '0;
      res_correct <= 1'b0;
      res_pc_next <= '0;
    end else begin
      res_valid <= issue_found;
      if (issue_found) begin
        res_val     <= pc[issue_idx] + 32'd4;
        res_tag     <= dest[issue_idx];
        res_correct <= issue_correct;
        res_pc_next <= issue_tgt;
      end
    end
  end

endmodule
